// File: rtl/hazard_forward_scoreboard.sv
// hazard_forward_scoreboard
// RV32IM hazard block: EX operand forwarding select, load-use interlock and a
// single-entry scoreboard for a multi-cycle MDU (DIV/REM) op with a latency
// watchdog. Optional perf counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_forward_scoreboard #(
  parameter int NUM_SRC     = 2,
  parameter int NUM_FWD     = 2,
  parameter int MDU_MAX_LAT = 40,
  localparam int SELW       = $clog2(NUM_FWD + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC*5-1:0]    rs_E,
  input  logic [NUM_SRC*5-1:0]    rs_D,
  input  logic [NUM_SRC-1:0]      rs_used_D,
  input  logic [4:0]              rd_D,
  input  logic                    regwrite_D,
  input  logic                    mdu_op_D,
  input  logic [4:0]              rd_E,
  input  logic                    regwrite_E,
  input  logic                    memread_E,
  input  logic                    mdu_start_E,
  input  logic                    flush_E,
  input  logic                    mdu_done,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD*5-1:0]    fwd_rd,
  output logic [NUM_SRC*SELW-1:0] fwd_sel,
  output logic                    stall_D,
  output logic                    bubble_E,
  output logic                    mdu_busy,
  output logic [4:0]              mdu_rd,
  output logic                    mdu_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]             stall_cnt,
  output logic [31:0]             mdu_stall_cnt
`endif
);

  localparam int WDW = $clog2(MDU_MAX_LAT + 1);

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e         state_q, state_d;
  logic [4:0]     mdu_rd_q, mdu_rd_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           timeout_q, timeout_d;

  logic [NUM_SRC*SELW-1:0] fwd_sel_c;
  logic start_ok, pend, clr;
  logic [4:0] pend_rd;
  logic load_hit, mdu_hit;
  logic load_use, mdu_raw, mdu_struct, hazard;

  // Forward select: scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    // NOTE: every comb-assigned signal gets a default first so no latch is inferred.
    fwd_sel_c = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (fwd_valid[k] && (fwd_rd[k*5 +: 5] != 5'd0) &&
            (fwd_rd[k*5 +: 5] == rs_E[i*5 +: 5])) begin
          fwd_sel_c[i*SELW +: SELW] = SELW'(k + 1);
        end
      end
    end
  end

  assign start_ok = mdu_start_E & ~flush_E;
  assign pend     = mdu_busy | start_ok;
  assign pend_rd  = start_ok ? rd_E : mdu_rd_q;
  // Regfile is write-first, so readers in the done cycle already see the result.
  assign clr      = mdu_done & mdu_busy & ~start_ok;

  // Match used ID-stage sources against the load destination and the pending MDU destination.
  always_comb begin
    load_hit = 1'b0;
    mdu_hit  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rs_used_D[i] && (rs_D[i*5 +: 5] == rd_E))    load_hit = 1'b1;
      if (rs_used_D[i] && (rs_D[i*5 +: 5] == pend_rd)) mdu_hit  = 1'b1;
    end
  end

  assign load_use   = memread_E & regwrite_E & ~flush_E & (rd_E != 5'd0) & load_hit;
  assign mdu_raw    = pend & ~clr & (pend_rd != 5'd0) &
                      (mdu_hit | (regwrite_D & (rd_D == pend_rd)));
  assign mdu_struct = mdu_op_D & pend & ~clr;
  assign hazard     = load_use | mdu_raw | mdu_struct;

  assign fwd_sel  = rst ? fwd_sel_c : '0;
  assign stall_D  = rst & hazard;
  assign bubble_E = rst & hazard;

  // MDU FSM state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated only with non-blocking assignments.
    if (!rst) begin
      state_q   <= ST_IDLE;
      mdu_rd_q  <= 5'd0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mdu_rd_q  <= mdu_rd_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  // MDU FSM next state: a new issue always restarts tracking, then done, then watchdog.
  always_comb begin
    state_d   = state_q;
    mdu_rd_d  = mdu_rd_q;
    wdog_d    = wdog_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d  = ST_BUSY;
          mdu_rd_d = rd_E;
          wdog_d   = '0;
        end
      end
      ST_BUSY: begin
        if (start_ok) begin
          mdu_rd_d = rd_E;
          wdog_d   = '0;
        end else if (mdu_done) begin
          state_d = ST_IDLE;
          wdog_d  = '0;
        end else if (wdog_q == WDW'(MDU_MAX_LAT - 1)) begin
          state_d   = ST_IDLE;
          wdog_d    = '0;
          timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // MDU FSM outputs, all taken from registers.
  always_comb begin
    mdu_busy    = (state_q == ST_BUSY);
    mdu_rd      = mdu_rd_q;
    mdu_timeout = timeout_q;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] mdu_stall_cnt_q, mdu_stall_cnt_d;

  // Saturating stall counters.
  always_comb begin
    stall_cnt_d     = stall_cnt_q;
    mdu_stall_cnt_d = mdu_stall_cnt_q;
    if (stall_D && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if ((mdu_raw | mdu_struct) && (mdu_stall_cnt_q != 32'hFFFF_FFFF))
      mdu_stall_cnt_d = mdu_stall_cnt_q + 32'd1;
  end

  // Counter registers, cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q     <= 32'd0;
      mdu_stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q     <= stall_cnt_d;
      mdu_stall_cnt_q <= mdu_stall_cnt_d;
    end
  end

  assign stall_cnt     = stall_cnt_q;
  assign mdu_stall_cnt = mdu_stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_scoreboard.sv
// Testbench for hazard_forward_scoreboard: directed vectors push expected
// outputs into a queue; a negedge monitor pops and compares.
module tb_hazard_forward_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rs_E, rs_D;
  logic [1:0]  rs_used_D;
  logic [4:0]  rd_D;
  logic        regwrite_D, mdu_op_D;
  logic [4:0]  rd_E;
  logic        regwrite_E, memread_E, mdu_start_E, flush_E, mdu_done;
  logic [1:0]  fwd_valid;
  logic [9:0]  fwd_rd;
  logic [3:0]  fwd_sel;
  logic        stall_D, bubble_E, mdu_busy, mdu_timeout;
  logic [4:0]  mdu_rd;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, mdu_stall_cnt;
`endif

  always #5 clk = ~clk;

  hazard_forward_scoreboard dut (
    .clk(clk), .rst(rst), .rs_E(rs_E), .rs_D(rs_D), .rs_used_D(rs_used_D),
    .rd_D(rd_D), .regwrite_D(regwrite_D), .mdu_op_D(mdu_op_D), .rd_E(rd_E),
    .regwrite_E(regwrite_E), .memread_E(memread_E), .mdu_start_E(mdu_start_E),
    .flush_E(flush_E), .mdu_done(mdu_done), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_sel(fwd_sel), .stall_D(stall_D), .bubble_E(bubble_E), .mdu_busy(mdu_busy),
    .mdu_rd(mdu_rd), .mdu_timeout(mdu_timeout)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .mdu_stall_cnt(mdu_stall_cnt)
`endif
  );

  typedef struct {
    string      name;
    logic [3:0] sel;
    logic       stall;
    logic       busy;
    logic [4:0] rd;
    logic       tmo;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    rs_E = '0; rs_D = '0; rs_used_D = '0; rd_D = '0; regwrite_D = 1'b0;
    mdu_op_D = 1'b0; rd_E = '0; regwrite_E = 1'b0; memread_E = 1'b0;
    mdu_start_E = 1'b0; flush_E = 1'b0; mdu_done = 1'b0;
    fwd_valid = '0; fwd_rd = '0;
  endtask

  // Push expectation for the current cycle, then advance to just after the next edge.
  task automatic expect_cyc(input string n, input logic [3:0] sel, input logic st,
                            input logic bz, input logic [4:0] rd, input logic tm);
    exp_t e;
    e.name = n; e.sel = sel; e.stall = st; e.busy = bz; e.rd = rd; e.tmo = tm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  // Monitor: compare on the falling edge whenever an expectation is queued.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check({mon_e.name, ".fwd_sel"},     32'(fwd_sel),     32'(mon_e.sel));
      check({mon_e.name, ".stall_D"},     32'(stall_D),     32'(mon_e.stall));
      check({mon_e.name, ".bubble_E"},    32'(bubble_E),    32'(mon_e.stall));
      check({mon_e.name, ".mdu_busy"},    32'(mdu_busy),    32'(mon_e.busy));
      check({mon_e.name, ".mdu_rd"},      32'(mdu_rd),      32'(mon_e.rd));
      check({mon_e.name, ".mdu_timeout"}, 32'(mdu_timeout), 32'(mon_e.tmo));
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;

    // Reset: combinational outputs gated even with live forwarding/hazard inputs.
    fwd_valid = 2'b11; fwd_rd = {5'd3, 5'd3}; rs_E = {5'd0, 5'd3};
    memread_E = 1'b1; regwrite_E = 1'b1; rd_E = 5'd5; rs_D = {5'd5, 5'd0}; rs_used_D = 2'b10;
    expect_cyc("reset", 4'b0000, 0, 0, 5'd0, 0);
    rst = 1'b1;

    // Forwarding.
    fwd_valid = 2'b11; fwd_rd = {5'd3, 5'd3}; rs_E = {5'd0, 5'd3};
    expect_cyc("fwd_mem_wins", 4'b0001, 0, 0, 5'd0, 0);
    fwd_valid = 2'b10; fwd_rd = {5'd3, 5'd3}; rs_E = {5'd3, 5'd3};
    expect_cyc("fwd_wb_only", 4'b1010, 0, 0, 5'd0, 0);
    fwd_valid = 2'b11; fwd_rd = {5'd0, 5'd0}; rs_E = {5'd0, 5'd0};
    expect_cyc("fwd_x0", 4'b0000, 0, 0, 5'd0, 0);
    fwd_valid = 2'b11; fwd_rd = {5'd8, 5'd4}; rs_E = {5'd4, 5'd8};
    expect_cyc("fwd_mixed", 4'b0110, 0, 0, 5'd0, 0);
    fwd_valid = 2'b00; fwd_rd = {5'd8, 5'd4}; rs_E = {5'd4, 5'd8};
    expect_cyc("fwd_invalid", 4'b0000, 0, 0, 5'd0, 0);

    // Load-use.
    memread_E = 1; regwrite_E = 1; rd_E = 5'd5; rs_D = {5'd5, 5'd0}; rs_used_D = 2'b10;
    expect_cyc("load_use", 4'b0000, 1, 0, 5'd0, 0);
    memread_E = 1; regwrite_E = 1; rd_E = 5'd5; rs_D = {5'd5, 5'd0}; rs_used_D = 2'b10; flush_E = 1;
    expect_cyc("load_use_flush", 4'b0000, 0, 0, 5'd0, 0);
    memread_E = 1; regwrite_E = 1; rd_E = 5'd5; rs_D = {5'd5, 5'd0}; rs_used_D = 2'b01;
    expect_cyc("load_use_unused", 4'b0000, 0, 0, 5'd0, 0);
    memread_E = 1; regwrite_E = 1; rd_E = 5'd0; rs_D = {5'd0, 5'd0}; rs_used_D = 2'b11;
    expect_cyc("load_use_x0", 4'b0000, 0, 0, 5'd0, 0);

    // MDU RAW interlock and release on done.
    mdu_start_E = 1; regwrite_E = 1; rd_E = 5'd7; rs_D = {5'd0, 5'd7}; rs_used_D = 2'b01;
    expect_cyc("mdu_start_raw", 4'b0000, 1, 0, 5'd0, 0);
    for (int i = 0; i < 10; i++) begin
      rs_D = {5'd0, 5'd7}; rs_used_D = 2'b01;
      expect_cyc("mdu_raw_wait", 4'b0000, 1, 1, 5'd7, 0);
    end
    mdu_done = 1; rs_D = {5'd0, 5'd7}; rs_used_D = 2'b01;
    expect_cyc("mdu_done_clr", 4'b0000, 0, 1, 5'd7, 0);
    rs_D = {5'd0, 5'd7}; rs_used_D = 2'b01;
    expect_cyc("mdu_idle", 4'b0000, 0, 0, 5'd7, 0);

    // Structural / WAW hazards and done+start in the same cycle.
    mdu_start_E = 1; rd_E = 5'd6;
    expect_cyc("start2", 4'b0000, 0, 0, 5'd7, 0);
    mdu_op_D = 1;
    expect_cyc("mdu_struct", 4'b0000, 1, 1, 5'd6, 0);
    regwrite_D = 1; rd_D = 5'd6;
    expect_cyc("mdu_waw", 4'b0000, 1, 1, 5'd6, 0);
    mdu_done = 1; mdu_start_E = 1; rd_E = 5'd9; rs_D = {5'd0, 5'd9}; rs_used_D = 2'b01;
    expect_cyc("done_and_start", 4'b0000, 1, 1, 5'd6, 0);
    expect_cyc("after_swap", 4'b0000, 0, 1, 5'd9, 0);
    mdu_start_E = 1; flush_E = 1; rd_E = 5'd12; mdu_done = 1;
    expect_cyc("flushed_start_done", 4'b0000, 0, 1, 5'd9, 0);
    expect_cyc("idle_after_flush", 4'b0000, 0, 0, 5'd9, 0);
    mdu_done = 1;
    expect_cyc("done_in_idle", 4'b0000, 0, 0, 5'd9, 0);
    expect_cyc("done_in_idle_after", 4'b0000, 0, 0, 5'd9, 0);

    // Watchdog: 40 busy cycles without done, then a single timeout pulse.
    mdu_start_E = 1; rd_E = 5'd10;
    expect_cyc("wd_start", 4'b0000, 0, 0, 5'd9, 0);
    for (int i = 0; i < 40; i++)
      expect_cyc("wd_busy", 4'b0000, 0, 1, 5'd10, 0);
    expect_cyc("wd_expire", 4'b0000, 0, 0, 5'd10, 1);
    expect_cyc("wd_after", 4'b0000, 0, 0, 5'd10, 0);

    // Reset in the middle of an outstanding op.
    mdu_start_E = 1; rd_E = 5'd11;
    expect_cyc("rst_start", 4'b0000, 0, 0, 5'd10, 0);
    expect_cyc("rst_busy", 4'b0000, 0, 1, 5'd11, 0);
    rst = 1'b0; rs_D = {5'd0, 5'd11}; rs_used_D = 2'b01; mdu_op_D = 1;
    fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd2}; rs_E = {5'd0, 5'd2};
    expect_cyc("rst_assert", 4'b0000, 0, 1, 5'd11, 0);
    rst = 1'b1;
    expect_cyc("rst_after", 4'b0000, 0, 0, 5'd0, 0);
    mdu_done = 1;
    expect_cyc("rst_done_ignored", 4'b0000, 0, 0, 5'd0, 0);
    expect_cyc("rst_idle", 4'b0000, 0, 0, 5'd0, 0);

    repeat (2) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
